// File: rtl/cpu_pkg.sv
// Constants shared by the core and its pipeline stages.
// Register-count and width defaults plus the address-width helper live here.
package cpu_pkg;

    localparam int REG_COUNT = 8;
    localparam int DATA_W    = 32;

    // Address width for n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks outstanding writers per register and raises
// the decode-stage stall on RAW (either source) or WAW hazards.
module reg_scoreboard #(
    parameter int NUM_REGS = cpu_pkg::REG_COUNT,
    parameter int ADDR_W   = cpu_pkg::addr_w(NUM_REGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                src0_used,
    input  logic [ADDR_W-1:0]   src0_addr,
    input  logic                src1_used,
    input  logic [ADDR_W-1:0]   src1_addr,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
);

    logic                hazard0;
    logic                hazard1;
    logic                waw;
    logic                accept;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // A write-back landing this cycle resolves the hazard only when it is forwarded.
    assign hazard0 = src0_used && pending[src0_addr] && !(BYPASS && wb_we && wb_addr == src0_addr);
    assign hazard1 = src1_used && pending[src1_addr] && !(BYPASS && wb_we && wb_addr == src1_addr);
    assign waw     = issue_we  && pending[issue_dst] && !(BYPASS && wb_we && wb_addr == issue_dst);

    assign stall  = issue_valid && (hazard0 || hazard1 || waw);
    assign accept = issue_valid && !stall;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept && issue_we && !(ZERO_REG && issue_dst == '0))
            set_mask[issue_dst] = 1'b1;
        if (wb_we)
            clr_mask[wb_addr] = 1'b1;
    end

    // Set is applied after clear so a new writer stays outstanding over an older write-back.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port,
// optional write-to-read bypass, optional hard-wired zero register and a debug port.
module regfile_scoreboard #(
    parameter int                     NUM_REGS  = cpu_pkg::REG_COUNT,
    parameter int                     DATA_W    = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0]      RESET_VAL = '0,
    parameter bit                     BYPASS    = 1'b1,
    parameter bit                     ZERO_REG  = 1'b0,
    localparam int                    ADDR_W    = cpu_pkg::addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd0_addr,
    output logic [DATA_W-1:0]   rd0_data,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    input  logic                issue_valid,
    input  logic                issue_src0_used,
    input  logic                issue_src1_used,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_dst,
    output logic                stall,
    input  logic                wb_we,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] pending,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Zero masking sits after the bypass so a forwarded write to R0 still reads 0.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (ZERO_REG && addr == '0)
            return '0;
        else if (BYPASS && we && waddr == addr)
            return wdata;
        else
            return stored;
    endfunction

    // NOTE: the array is flop-based and architecturally resets to RESET_VAL, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VAL;
        end else if (wb_we && !(ZERO_REG && wb_addr == '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign rd0_data = read_port(rd0_addr, regs[rd0_addr], wb_we, wb_addr, wb_data);
    assign rd1_data = read_port(rd1_addr, regs[rd1_addr], wb_we, wb_addr, wb_data);
    assign dbg_data = regs[dbg_addr];

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .src0_used   (issue_src0_used),
        .src0_addr   (rd0_addr),
        .src1_used   (issue_src1_used),
        .src1_addr   (rd1_addr),
        .issue_we    (issue_we),
        .issue_dst   (issue_dst),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .stall       (stall),
        .pending     (pending)
    );

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined core with two combinational read ports, one write-back port, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. The block sits between decode and write-back. It replaces the fixed two-register file, and it generates the decode-stage stall for RAW and WAW hazards. A debug read port feeds the HEX display logic.

## Interface
Parameters:
- NUM_REGS, 8, number of architectural registers (power of two, ≥2)
- DATA_W, 32, register width in bits
- RESET_VAL, 0, value loaded into every register on reset
- BYPASS, 1, 1 = write-back data forwarded to read ports and clears hazards in the same cycle; 0 = no forwarding
- ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never pending
- ADDR_W (localparam), $clog2(NUM_REGS)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- rd0_addr  in  ADDR_W  read port 0 address
- rd0_data  out  DATA_W  read port 0 data
- rd1_addr  in  ADDR_W  read port 1 address
- rd1_data  out  DATA_W  read port 1 data
- issue_valid  in  1  decode presents an instruction this cycle
- issue_src0_used  in  1  instruction reads rd0_addr
- issue_src1_used  in  1  instruction reads rd1_addr
- issue_we  in  1  instruction will write issue_dst
- issue_dst  in  ADDR_W  destination register of the issuing instruction
- stall  out  1  decode must hold; the issue is not accepted
- wb_we  in  1  write-back valid
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data
- pending  out  NUM_REGS  scoreboard bits, registered
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, raw array contents with no bypass

## Operation
- Reads are combinational. If BYPASS=1, wb_we=1, and wb_addr equals a read address, that read port returns wb_data. Otherwise it returns the array value.
- If ZERO_REG=1, any read of address 0 returns 0, including through bypass.
- A write occurs on a rising edge with wb_we=1 and reset=0. Writes to address 0 are dropped when ZERO_REG=1.
- Hazard for a source port = the port's `used` flag is set and `pending[addr]` is 1. With BYPASS=1, a hazard is cleared if wb_we=1 and wb_addr equals that address in the same cycle.
- WAW hazard = issue_we=1 and `pending[issue_dst]` is 1, with the same wb clearing rule.
- stall = issue_valid & (hazard0 | hazard1 | waw). It is purely combinational and 0 when issue_valid=0.
- Issue is accepted when issue_valid=1 and stall=0. On the next edge, if issue_we=1, `pending[issue_dst]` is set.
- On wb_we=1, `pending[wb_addr]` is cleared on the next edge.
- Simultaneous accepted issue and write-back to the same register: the set wins, so pending stays 1 because the new writer is outstanding.
- A write-back to a non-pending register is legal. The data is written and pending stays 0.
- Reset: all registers load RESET_VAL and pending is cleared to all-zero. Issue and wb inputs are ignored in the reset cycle. A reset asserted mid-operation discards every outstanding pending bit.

## Timing
- Read latency is 0 cycles. A non-bypassed write is visible on rd*_data in the cycle after the edge.
- Stall latency is 0 cycles, decided from the current pending bits and the current wb inputs.
- A pending bit becomes visible one edge after the accepted issue. An instruction issued in cycle N that writes R blocks readers of R from cycle N+1.
- Output values after reset: pending=0, stall=0, dbg_data=RESET_VAL. rd*_data=RESET_VAL, or 0 for address 0 when ZERO_REG=1.
- Address inputs are always in range because NUM_REGS is a power of two, so there is no out-of-range case.

## Structure
- Shared package cpu_pkg holds the default REG_COUNT (8), DATA_W (32), and the addr_w() helper function. The core and its pipeline stages use the same constants.
- One sub-module, reg_scoreboard, owns the pending vector, the set/clear logic, and the hazard/stall generation.
- The array, the bypass muxes, and the ZERO_REG masking stay in regfile_scoreboard.

## Test plan
- Reset then read: assert reset with RESET_VAL=3 → after reset, all rd/dbg ports return 3 and pending=0.
- Plain write: wb R2←0x55 → in the same cycle rd0_addr=2 returns 0x55 (BYPASS=1); in the next cycle dbg_data=0x55; with BYPASS=0 the same-cycle read returns the old value.
- RAW stall: issue dst=R5, then next cycle issue with src0=R5 → stall=1 until the cycle wb_addr=5 (BYPASS=1), then stall=0 and rd0_data=wb_data. With BYPASS=0, stall stays high through that cycle and clears one cycle later.
- WAW plus simultaneous set/clear: R3 pending, wb R3 while issuing a new dst=R3 → no stall, and pending[3] stays 1 afterwards.
- ZERO_REG=1: wb R0←0xFF, issue dst=R0, then read R0 → data=0, pending[0]=0, stall=0.
- Reset mid-operation: set pending on R1 and R4, assert reset for 1 cycle → pending=0, registers=RESET_VAL, and a src0=R1 issue does not stall.
